// File: rtl/exe_stage.sv
// Execute stage: ALU, flag generation and the E->M pipeline register.
// Define EXE_MUL_EN for an iterative 32-cycle shift-add multiply on ALUctrl 111; otherwise 111 passes operand B.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_E,
  input  logic        regw_E,
  input  logic        memw_E,
  input  logic        regmem_E,
  input  logic        ALUope_E,
  input  logic [2:0]  ALUctrl_E,
  input  logic [3:0]  regScr_E,
  input  logic [31:0] regA_E,
  input  logic [31:0] regB_E,
  input  logic [31:0] inm_E,
  output logic        stall_E,
  output logic        regw_M,
  output logic        memw_M,
  output logic        regmem_M,
  output logic [3:0]  regScr_M,
  output logic [31:0] ALUres_M,
  output logic [31:0] wdata_M,
  output logic [3:0]  flags_M
);
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 5;
  localparam int unsigned FW = 4;

  logic [DW-1:0] opb;
  logic [DW-1:0] alu_res;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic          alu_c;
  logic          alu_v;
  logic [FW-1:0] alu_flags;

  // Next values for the M register; bubble unless a stage process loads them.
  logic          m_regw;
  logic          m_memw;
  logic          m_regmem;
  logic [RW-1:0] m_scr;
  logic [DW-1:0] m_res;
  logic [DW-1:0] m_wdata;
  logic [FW-1:0] m_flags;

  // Single-cycle ALU with N,Z,C,V; C is carry for add and no-borrow for sub.
  always_comb begin
    opb     = ALUope_E ? inm_E : regB_E;
    sum     = {1'b0, regA_E} + {1'b0, opb};
    diff    = {1'b0, regA_E} - {1'b0, opb};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUctrl_E)
      3'b000: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (regA_E[DW-1] == opb[DW-1]) && (sum[DW-1] != regA_E[DW-1]);
      end
      3'b001: begin
        alu_res = diff[DW-1:0];
        alu_c   = ~diff[DW];
        alu_v   = (regA_E[DW-1] != opb[DW-1]) && (diff[DW-1] != regA_E[DW-1]);
      end
      3'b010:  alu_res = regA_E & opb;
      3'b011:  alu_res = regA_E | opb;
      3'b100:  alu_res = regA_E ^ opb;
      3'b101:  alu_res = regA_E << opb[CW-1:0];
      3'b110:  alu_res = regA_E >> opb[CW-1:0];
`ifdef EXE_MUL_EN
      default: alu_res = '0;
`else
      default: alu_res = opb;
`endif
    endcase
    alu_flags = {alu_res[DW-1], alu_res == '0, alu_c, alu_v};
  end

`ifdef EXE_MUL_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] mcand_q;
  logic [DW-1:0] mplier_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt_q;
  logic          regw_q;
  logic          memw_q;
  logic          regmem_q;
  logic [RW-1:0] scr_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stall_E  = 1'b0;
    m_regw   = 1'b0;
    m_memw   = 1'b0;
    m_regmem = 1'b0;
    m_scr    = '0;
    m_res    = '0;
    m_wdata  = '0;
    m_flags  = '0;
    if (flush_E) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ALUctrl_E == 3'b111) begin
            stall_E = 1'b1;
            state_d = RUN;
          end else begin
            m_regw   = regw_E;
            m_memw   = memw_E;
            m_regmem = regmem_E;
            m_scr    = regScr_E;
            m_res    = alu_res;
            m_wdata  = regB_E;
            m_flags  = alu_flags;
          end
        end
        RUN: begin
          stall_E = 1'b1;
          if (cnt_q == CW'(DW - 1)) state_d = DONE;
        end
        DONE: begin
          state_d  = IDLE;
          m_regw   = regw_q;
          m_memw   = memw_q;
          m_regmem = regmem_q;
          m_scr    = scr_q;
          m_res    = acc_q;
          m_wdata  = wdata_q;
          m_flags  = {acc_q[DW-1], acc_q == '0, 2'b00};
        end
        default: state_d = IDLE;
      endcase
    end
    if (rst) stall_E = 1'b0;
  end

  // Multiplier datapath: latch operands on entry, then one shift-add step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      regmem_q <= 1'b0;
      scr_q    <= '0;
    end else if (state_q == IDLE && state_d == RUN) begin
      mcand_q  <= regA_E;
      mplier_q <= opb;
      acc_q    <= '0;
      cnt_q    <= '0;
      wdata_q  <= regB_E;
      regw_q   <= regw_E;
      memw_q   <= memw_E;
      regmem_q <= regmem_E;
      scr_q    <= regScr_E;
    end else if (state_q == RUN && state_d != IDLE) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
`else
  assign stall_E = 1'b0;

  always_comb begin
    m_regw   = 1'b0;
    m_memw   = 1'b0;
    m_regmem = 1'b0;
    m_scr    = '0;
    m_res    = '0;
    m_wdata  = '0;
    m_flags  = '0;
    if (!flush_E) begin
      m_regw   = regw_E;
      m_memw   = memw_E;
      m_regmem = regmem_E;
      m_scr    = regScr_E;
      m_res    = alu_res;
      m_wdata  = regB_E;
      m_flags  = alu_flags;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      regw_M   <= 1'b0;
      memw_M   <= 1'b0;
      regmem_M <= 1'b0;
      regScr_M <= '0;
      ALUres_M <= '0;
      wdata_M  <= '0;
      flags_M  <= '0;
    end else begin
      regw_M   <= m_regw;
      memw_M   <= m_memw;
      regmem_M <= m_regmem;
      regScr_M <= m_scr;
      ALUres_M <= m_res;
      wdata_M  <= m_wdata;
      flags_M  <= m_flags;
    end
  end
endmodule
